spike_decoder: RTL

- Read-out stage at the output end of the SNN classifier. It consumes the spike[9:0] vector produced by the output-neuron layer.
- Over a fixed presentation window it counts spikes per output neuron, then scans the counts to pick the winning class (argmax).
- It reports the class, its count and tie/no-spike flags through a valid/ready handshake to the host or evaluation logic.

---
 rtl/spike_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spike_decoder.sv
// Spike-count read-out: counts per-neuron spikes over a WIN_LEN window, then argmax-scans one neuron per cycle.
// Latency: result valid WIN_LEN+N_OUT+1 cycles after an accepted start.
// Backpressure: result held in HOLD until res_ready; start is ignored while busy.

module spike_decoder #(
   parameter int N_OUT   = 10,
   parameter int CNT_W   = 8,
   parameter int WIN_LEN = 1000,
   parameter int WIN_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             learn,
   input  logic [N_OUT-1:0] spike,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [3:0]       winner,
   output logic [CNT_W-1:0] win_cnt,
   output logic             tie,
   output logic             no_spike,
   output logic             res_learn
);

   typedef enum logic [1:0] {IDLE, COUNT, SCAN, HOLD} state_t;

   typedef struct packed {
      logic [3:0]       winner;
      logic [CNT_W-1:0] win_cnt;
      logic             tie;
      logic             no_spike;
   } res_t;

   localparam logic [WIN_W-1:0] WIN_END  = WIN_W'(WIN_LEN);
   localparam logic [3:0]       LAST_IDX = 4'(N_OUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_q;
   logic [3:0]       scan_idx_q;
   logic [CNT_W-1:0] cnt_q [N_OUT];
   logic [CNT_W-1:0] best_q;
   logic [3:0]       best_idx_q;
   logic             tie_q;
   res_t             res_q;
   logic             learn_q;

   logic             win_done;
   logic             scan_last;
   logic [CNT_W-1:0] cur_cnt;
   logic [CNT_W-1:0] best_d;
   logic [3:0]       best_idx_d;
   logic             tie_d;

   // win_q reaches WIN_END after the last sample; that edge moves to SCAN without sampling
   assign win_done  = (win_q == WIN_END);
   assign scan_last = (scan_idx_q == LAST_IDX);
   assign cur_cnt   = cnt_q[scan_idx_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = COUNT;
         COUNT:   if (win_done)  state_d = SCAN;
         SCAN:    if (scan_last) state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Running argmax: strict greater-than keeps the lowest index on equal counts
   always_comb begin
      best_d     = best_q;
      best_idx_d = best_idx_q;
      tie_d      = tie_q;
      if (scan_idx_q == 4'd0) begin
         best_d     = cur_cnt;
         best_idx_d = 4'd0;
         tie_d      = 1'b0;
      end else if (cur_cnt > best_q) begin
         best_d     = cur_cnt;
         best_idx_d = scan_idx_q;
         tie_d      = 1'b0;
      end else if (cur_cnt == best_q) begin
         tie_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q      <= '0;
         scan_idx_q <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         tie_q      <= 1'b0;
         res_q      <= '0;
         learn_q    <= 1'b0;
         for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  win_q   <= '0;
                  learn_q <= learn;
                  for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
               end
            end
            COUNT: begin
               scan_idx_q <= '0;
               if (!win_done) begin
                  win_q <= win_q + WIN_W'(1);
                  for (int i = 0; i < N_OUT; i++) begin
                     if (spike[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                  end
               end
            end
            SCAN: begin
               best_q     <= best_d;
               best_idx_q <= best_idx_d;
               tie_q      <= tie_d;
               scan_idx_q <= scan_idx_q + 4'd1;
               if (scan_last) begin
                  res_q.win_cnt  <= best_d;
                  res_q.no_spike <= (best_d == '0);
                  res_q.winner   <= (best_d == '0) ? 4'd0 : best_idx_d;
                  res_q.tie      <= (best_d == '0) ? 1'b0 : tie_d;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == HOLD);
   assign winner    = res_q.winner;
   assign win_cnt   = res_q.win_cnt;
   assign tie       = res_q.tie;
   assign no_spike  = res_q.no_spike;
   assign res_learn = learn_q;

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (res_valid && !res_ready) |=> (res_valid && $stable(res_q) && $stable(learn_q)));

   a_win_bound: assert property (@(posedge clk) disable iff (!rst_n) win_q <= WIN_END);

endmodule
